// File: rtl/alu4_pkg.sv
// Shared definitions for the round-robin ALU scheduler.
// Contents: operand/result widths, opcode encodings, FSM state type,
// the per-lane command payload, and helpers for illegal-op handling.
package alu4_pkg;

    localparam int unsigned OPW = 4;
    localparam int unsigned DW  = 4;
    localparam int unsigned RW  = 8;

    localparam logic [OPW-1:0] OP_ADD = 4'h0;
    localparam logic [OPW-1:0] OP_SUB = 4'h1;
    localparam logic [OPW-1:0] OP_MUL = 4'h2;
    localparam logic [OPW-1:0] OP_DIV = 4'h3;
    localparam logic [OPW-1:0] OP_AND = 4'h4;
    localparam logic [OPW-1:0] OP_OR  = 4'h5;
    localparam logic [OPW-1:0] OP_XOR = 4'h6;
    localparam logic [OPW-1:0] OP_SHL = 4'h7;
    localparam logic [OPW-1:0] OP_SHR = 4'h8;
    localparam logic [OPW-1:0] OP_MIN = 4'h9;
    localparam logic [OPW-1:0] OP_LT  = 4'hA;
    localparam logic [OPW-1:0] OP_EQ  = 4'hB;
    localparam logic [OPW-1:0] OP_GT  = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One requester's operation as presented on its lane.
    typedef struct packed {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
    } alu_cmd_t;

    // Opcodes above OP_GT are undefined; divide by zero is rejected.
    function automatic logic is_legal(input logic [OPW-1:0] op, input logic [DW-1:0] b);
        return (op <= OP_GT) && !((op == OP_DIV) && (b == DW'(0)));
    endfunction

    // Result byte reported for a rejected operation.
    function automatic logic [RW-1:0] err_data(input logic [OPW-1:0] op);
        return (op == OP_DIV) ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/alu4_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   valid  in   NREQ  lanes requesting
//   ptr    in   IDW   lane with highest priority this cycle
//   grant  out  NREQ  one-hot grant (all zero when nothing valid)
//   index  out  IDW   index of the granted lane
//   found  out  1     a lane was granted
module alu4_rr_arbiter
    import alu4_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  index,
    output logic            found
);

    logic [IDW-1:0] lane;

    // Walk lanes from ptr upward with wraparound; first valid lane wins.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        lane  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            lane = IDW'((32'(ptr) + k) % NREQ);
            if (!found && valid[lane]) begin
                found       = 1'b1;
                grant[lane] = 1'b1;
                index       = lane;
            end
        end
    end

endmodule

// File: rtl/alu4_rr_scheduler.sv
// Shares one 4-bit ALU among NREQ requesters with round-robin arbitration.
// Legal operations are latched onto the ALU inputs and the result sampled
// ALU_LAT cycles later; illegal operations are answered directly with an
// error response and never disturb the ALU inputs.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   req_valid   in   NREQ    lane has an operation pending
//   req_ready   out  NREQ    one-hot grant (combinational, IDLE only)
//   req_op/a/b  in   4*NREQ  per-lane opcode / operands, lane i at [4i+3:4i]
//   alu_op/a/b  out  4       ALU inputs, change only on a legal transfer
//   alu_result  in   8       ALU output
//   rsp_valid   out  1       response available
//   rsp_ready   in   1       consumer accepts response
//   rsp_id      out  IDW     owning lane
//   rsp_data    out  8       result byte
//   rsp_err     out  1       illegal operation
module alu4_rr_scheduler
    import alu4_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned ALU_LAT = 1,
    localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [OPW*NREQ-1:0] req_op,
    input  logic [DW*NREQ-1:0]  req_a,
    input  logic [DW*NREQ-1:0]  req_b,
    output logic [OPW-1:0]      alu_op,
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    input  logic [RW-1:0]       alu_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [RW-1:0]       rsp_data,
    output logic                rsp_err
);

    localparam int unsigned      CNTW     = 3;
    localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(ALU_LAT - 1);
    localparam logic [IDW-1:0]   ID_LAST  = IDW'(NREQ - 1);

    state_t          state;
    state_t          state_next;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_next;
    logic [IDW-1:0]  rr_ptr;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win_id;
    logic            win_any;
    alu_cmd_t        lane_cmd [NREQ];
    alu_cmd_t        win_cmd;
    logic            win_legal;

    logic            xfer;
    logic            xfer_legal;
    logic            capture;

    // Unpack flat lane buses into per-lane commands.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign lane_cmd[i] = {req_op[OPW*i +: OPW], req_a[DW*i +: DW], req_b[DW*i +: DW]};
    end

    alu4_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .index (win_id),
        .found (win_any)
    );

    assign win_cmd   = lane_cmd[win_id];
    assign win_legal = is_legal(win_cmd.op, win_cmd.b);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state, grant and datapath load strobes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = '0;
        xfer       = 1'b0;
        xfer_legal = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = grant;
                // grant only ever lands on a valid lane, so any grant is a transfer
                if (win_any) begin
                    xfer = 1'b1;
                    if (win_legal) begin
                        xfer_legal = 1'b1;
                        cnt_next   = '0;
                        state_next = ST_EXEC;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                cnt_next = cnt + CNTW'(1);
                if (cnt == CNT_LAST) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pointer, ALU input latch and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= (state_next == ST_RESP);
            if (xfer) begin
                rr_ptr <= (win_id == ID_LAST) ? '0 : win_id + IDW'(1);
                rsp_id <= win_id;
                if (!win_legal) begin
                    rsp_data <= err_data(win_cmd.op);
                    rsp_err  <= 1'b1;
                end
            end
            if (xfer_legal) begin
                alu_op <= win_cmd.op;
                alu_a  <= win_cmd.a;
                alu_b  <= win_cmd.b;
            end
            if (capture) begin
                rsp_data <= alu_result;
                rsp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu4_rr_scheduler.sv
// Directed bench for alu4_rr_scheduler (NREQ=2, ALU_LAT=1) with a
// combinational ALU model and an expected-response scoreboard.
module tb_alu4_rr_scheduler;
    import alu4_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [3:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [0:0] rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_err;

    typedef struct packed {
        logic [0:0] id;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    rsp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    alu4_rr_scheduler #(
        .NREQ    (2),
        .ALU_LAT (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: single-cycle combinational datapath.
    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            OP_ADD:  alu_result = {4'h0, alu_a} + {4'h0, alu_b};
            OP_SUB:  alu_result = {4'h0, alu_a} - {4'h0, alu_b};
            OP_MUL:  alu_result = {4'h0, alu_a} * {4'h0, alu_b};
            OP_DIV:  alu_result = (alu_b == 4'h0) ? 8'hFF : {4'h0, alu_a / alu_b};
            OP_AND:  alu_result = {4'h0, alu_a & alu_b};
            OP_OR:   alu_result = {4'h0, alu_a | alu_b};
            OP_XOR:  alu_result = {4'h0, alu_a ^ alu_b};
            OP_SHL:  alu_result = {4'h0, alu_a} << alu_b;
            OP_SHR:  alu_result = {4'h0, alu_a >> alu_b};
            OP_MIN:  alu_result = {4'h0, (alu_a < alu_b) ? alu_a : alu_b};
            OP_LT:   alu_result = (alu_a < alu_b) ? 8'hFF : 8'h00;
            OP_EQ:   alu_result = (alu_a == alu_b) ? 8'hFF : 8'h00;
            OP_GT:   alu_result = (alu_a > alu_b) ? 8'hFF : 8'h00;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input int lane, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        req_op[lane*4 +: 4] = op;
        req_a[lane*4 +: 4]  = a;
        req_b[lane*4 +: 4]  = b;
        req_valid[lane]     = 1'b1;
    endtask

    task automatic send(input int lane, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp_data, input logic exp_err);
        rsp_t e;
        drive(lane, op, a, b);
        e.id   = 1'(lane);
        e.data = exp_data;
        e.err  = exp_err;
        sb.push_back(e);
    endtask

    task automatic check_rsp(input string tag);
        rsp_t e;
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected a pending entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_id"},   32'(rsp_id),   32'(e.id));
            check({tag, "_data"}, 32'(rsp_data), 32'(e.data));
            check({tag, "_err"},  32'(rsp_err),  32'(e.err));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_alu_op"},    32'(alu_op),    32'd0);
        check({tag, "_alu_a"},     32'(alu_a),     32'd0);
        check({tag, "_alu_b"},     32'(alu_b),     32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Called in the transfer cycle T of a legal op; ends in the IDLE cycle after the response.
    task automatic finish_legal(input int lane, input string tag);
        step();
        req_valid[lane] = 1'b0;
        #1;
        check({tag, "_exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_exec_req_ready"}, 32'(req_ready), 32'd0);
        step();
        #1;
        check_rsp(tag);
        step();
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_op    = 8'h00;
        req_a     = 8'h00;
        req_b     = 8'h00;
        rsp_ready = 1'b1;

        do_reset();
        check_reset_outputs("reset");

        // Single legal op: grant in T, response at T+2.
        step();
        send(0, OP_ADD, 4'h9, 4'h8, 8'h11, 1'b0);
        #1;
        check("t1_grant", 32'(req_ready), 32'h1);
        step();
        req_valid[0] = 1'b0;
        #1;
        check("t1_t1_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t1_alu_op", 32'(alu_op), 32'(OP_ADD));
        check("t1_alu_a",  32'(alu_a),  32'h9);
        check("t1_alu_b",  32'(alu_b),  32'h8);
        step();
        #1;
        check_rsp("t1");
        step();
        #1;
        check("t1_rsp_drop", 32'(rsp_valid), 32'd0);

        // Contention from reset: lane0 first, then lane1, then lane0 again.
        do_reset();
        step();
        send(0, OP_MUL, 4'h3, 4'h5, 8'h0F, 1'b0);
        send(1, OP_SUB, 4'h7, 4'h2, 8'h05, 1'b0);
        #1;
        check("t2_first_grant", 32'(req_ready), 32'h1);
        finish_legal(0, "t2a");
        check("t2_second_grant", 32'(req_ready), 32'h2);
        finish_legal(1, "t2b");
        step();
        send(0, OP_ADD, 4'h2, 4'h3, 8'h05, 1'b0);
        send(1, OP_SUB, 4'h1, 4'h2, 8'hFF, 1'b0);
        #1;
        check("t2_third_grant", 32'(req_ready), 32'h1);
        finish_legal(0, "t2c");
        check("t2_fourth_grant", 32'(req_ready), 32'h2);
        finish_legal(1, "t2d");

        // Divide by zero on lane1: response at T+1, ALU inputs untouched.
        step();
        send(1, OP_DIV, 4'h6, 4'h0, 8'hFF, 1'b1);
        #1;
        check("t3_grant", 32'(req_ready), 32'h2);
        step();
        req_valid[1] = 1'b0;
        #1;
        check_rsp("t3");
        check("t3_alu_op", 32'(alu_op), 32'(OP_SUB));
        check("t3_alu_a",  32'(alu_a),  32'h1);
        check("t3_alu_b",  32'(alu_b),  32'h2);
        step();
        #1;
        check("t3_rsp_drop", 32'(rsp_valid), 32'd0);

        // Undefined opcode, then a legal compare.
        step();
        send(0, 4'hE, 4'h3, 4'h4, 8'h00, 1'b1);
        #1;
        check("t4_grant", 32'(req_ready), 32'h1);
        step();
        req_valid[0] = 1'b0;
        #1;
        check_rsp("t4a");
        check("t4_alu_op_kept", 32'(alu_op), 32'(OP_SUB));
        step();
        #1;
        step();
        send(0, OP_EQ, 4'hA, 4'hA, 8'hFF, 1'b0);
        #1;
        check("t4_eq_grant", 32'(req_ready), 32'h1);
        finish_legal(0, "t4b");
        check("t4_alu_op_eq", 32'(alu_op), 32'(OP_EQ));

        // Back-pressure: response held for 5 cycles while lane0 keeps requesting.
        step();
        rsp_ready = 1'b0;
        send(0, OP_ADD, 4'h5, 4'h6, 8'h0B, 1'b0);
        #1;
        check("t5_grant", 32'(req_ready), 32'h1);
        step();
        send(0, OP_OR, 4'h4, 4'h1, 8'h05, 1'b0);
        #1;
        check("t5_exec_req_ready", 32'(req_ready), 32'd0);
        step();
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid",     32'(rsp_valid), 32'd1);
            check("t5_hold_data",      32'(rsp_data),  32'h0B);
            check("t5_hold_id",        32'(rsp_id),    32'd0);
            check("t5_hold_err",       32'(rsp_err),   32'd0);
            check("t5_hold_req_ready", 32'(req_ready), 32'd0);
            step();
            #1;
        end
        rsp_ready = 1'b1;
        check_rsp("t5a");
        step();
        #1;
        check("t5_idle_grant", 32'(req_ready), 32'h1);
        finish_legal(0, "t5b");

        // Reset in EXEC: operation discarded, everything back to reset values.
        step();
        drive(0, OP_MUL, 4'h2, 4'h2);
        #1;
        check("t6_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        rst       = 1'b1;
        #1;
        check("t6_exec_alu_op", 32'(alu_op), 32'(OP_MUL));
        check("t6_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check_reset_outputs("t6");
        drive(0, OP_ADD, 4'h1, 4'h1);
        drive(1, OP_ADD, 4'h2, 4'h2);
        #1;
        check("t6_ptr_reset_grant", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        #1;
        check("t6_withdrawn", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("t6_no_rsp", 32'(rsp_valid), 32'd0);
            check("t6_no_latch", 32'(alu_op), 32'd0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
